// File: rtl/seq_divider.sv
// Multi-cycle restoring divider that works in signed or unsigned mode.
// It produces one quotient bit per cycle, then a fix-up cycle applies the signs.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int         CW     = 6;
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ZERO - v;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? neg(v) : v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic             zero_q, zero_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;

  assign shift_s = {rem_q, dvd_q[WIDTH-1]};
  assign diff_s  = shift_s - {1'b0, bmag_q};
  assign ge_s    = (shift_s >= {1'b0, bmag_q});

  // Next-state, datapath step and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    bmag_d  = bmag_q;
    zero_d  = zero_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          negq_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          negr_d = signed_mode & a[WIDTH-1];
          rem_d  = ZERO;
          cnt_d  = CW'(WIDTH - 1);
          bmag_d = mag(b, signed_mode);
          if (b == ZERO) begin
            // Raw dividend is kept so the remainder reports a unchanged.
            zero_d  = 1'b1;
            dvd_d   = a;
            state_d = S_FIX;
          end else begin
            zero_d  = 1'b0;
            dvd_d   = mag(a, signed_mode);
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        rem_d = ge_s ? diff_s[WIDTH-1:0] : shift_s[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ge_s};
        if (cnt_q == 6'd0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_FIX: begin
        if (zero_q) begin
          quo_d  = ONES;
          remo_d = dvd_q;
          dbz_d  = 1'b1;
        end else begin
          quo_d  = negq_q ? neg(dvd_q) : dvd_q;
          remo_d = negr_q ? neg(rem_q) : rem_q;
          dbz_d  = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      dvd_q   <= ZERO;
      rem_q   <= ZERO;
      bmag_q  <= ZERO;
      zero_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= ZERO;
      remo_q  <= ZERO;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      bmag_q  <= bmag_d;
      zero_q  <= zero_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8): vector table plus hand-written
// sequences for an ignored mid-operation start and a reset abort.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int tests  = 0;
  int failed = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Issues one division; optionally pulses a second start (9/2) on edge inj.
  // While the divider is still in its CALC cycles the previous result must hold.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                        input int inj, input logic [7:0] hold_q,
                        output int lat, output int pulses);
    logic busy1;
    @(negedge clk);
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    busy1 = busy;
    start = 1'b0; a = 8'hA5; b = 8'h5A; signed_mode = ~sm;
    chk("busy_after_start", {31'd0, busy1}, 32'd1);
    lat = 0;
    pulses = 0;
    for (int j = 1; j <= 20; j++) begin
      if (j == inj) begin
        start = 1'b1; a = 8'd9; b = 8'd2; signed_mode = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (lat == 0) lat = j + 1;
      end
      if (j == 4 && bv != 8'd0) chk("hold_during_calc", {24'd0, quotient}, {24'd0, hold_q});
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, pulses;
    logic [7:0] prev_q;

    vecs[0]  = '{8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   1'b0, 10};
    vecs[1]  = '{8'h9C,  8'd7,   1'b1, 8'hF2,  8'hFE,  1'b0, 10};
    vecs[2]  = '{8'd100, 8'hF9,  1'b1, 8'hF2,  8'h02,  1'b0, 10};
    vecs[3]  = '{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0, 10};
    vecs[4]  = '{8'h80,  8'hFF,  1'b0, 8'h00,  8'h80,  1'b0, 10};
    vecs[5]  = '{8'h55,  8'h00,  1'b0, 8'hFF,  8'h55,  1'b1, 2};
    vecs[6]  = '{8'd10,  8'd3,   1'b0, 8'd3,   8'd1,   1'b0, 10};
    vecs[7]  = '{8'h85,  8'h00,  1'b1, 8'hFF,  8'h85,  1'b1, 2};
    vecs[8]  = '{8'h9C,  8'hF9,  1'b1, 8'h0E,  8'hFE,  1'b0, 10};
    vecs[9]  = '{8'hFF,  8'h01,  1'b0, 8'hFF,  8'h00,  1'b0, 10};
    vecs[10] = '{8'd7,   8'd9,   1'b0, 8'd0,   8'd7,   1'b0, 10};
    vecs[11] = '{8'hF9,  8'd2,   1'b1, 8'hFD,  8'hFF,  1'b0, 10};
    vecs[12] = '{8'hFF,  8'hFF,  1'b1, 8'h01,  8'h00,  1'b0, 10};

    // Reset state, with start held high during reset
    start = 1'b1; a = 8'd5; b = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", {24'd0, quotient}, 32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    prev_q = 8'd0;
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sm, 0, prev_q, lat, pulses);
      chk($sformatf("v%0d_quotient", i), {24'd0, quotient}, {24'd0, vecs[i].q});
      chk($sformatf("v%0d_remainder", i), {24'd0, remainder}, {24'd0, vecs[i].r});
      chk($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_pulses", i), pulses, 32'd1);
      prev_q = vecs[i].q;
    end

    // Second start mid-operation is ignored
    run_op(8'd200, 8'd3, 1'b0, 3, prev_q, lat, pulses);
    chk("ign_quotient", {24'd0, quotient}, 32'd66);
    chk("ign_remainder", {24'd0, remainder}, 32'd2);
    chk("ign_latency", lat, 32'd10);
    chk("ign_pulses", pulses, 32'd1);

    // Reset in the middle of CALC aborts without a done pulse
    @(negedge clk);
    a = 8'd100; b = 8'd7; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_quotient", {24'd0, quotient}, 32'd0);
    chk("abort_remainder", {24'd0, remainder}, 32'd0);
    start = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    pulses = 0;
    for (int j = 0; j < 15; j++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("abort_no_activity", pulses, 32'd0);
    run_op(8'd15, 8'd4, 1'b0, 0, 8'd0, lat, pulses);
    chk("after_rst_quotient", {24'd0, quotient}, 32'd3);
    chk("after_rst_remainder", {24'd0, remainder}, 32'd3);
    chk("after_rst_latency", lat, 32'd10);
    chk("after_rst_pulses", pulses, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port start  input  1  request a division; accepted only when busy=0.
REQ-005 SHALL provide port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL provide port a  input  WIDTH  dividend; sampled with start.
REQ-007 SHALL provide port b  input  WIDTH  divisor; sampled with start.
REQ-008 SHALL provide port busy  output  1  high while a division is in progress.
REQ-009 SHALL provide port done  output  1  single-cycle pulse marking valid results.
REQ-010 SHALL provide port quotient  output  WIDTH  result quotient.
REQ-011 SHALL provide port remainder  output  WIDTH  result remainder.
REQ-012 SHALL provide port div_by_zero  output  1  set when the completed operation had b=0.

Function
REQ-013 SHALL implement a state machine with states IDLE, CALC, FIX, DONE.
REQ-014 SHALL, in IDLE with start=1 at a rising edge, latch a, b, signed_mode, then go to CALC (b!=0) or FIX (b=0).
REQ-015 SHALL ignore start while busy=1; latched operands are unaffected.
REQ-016 SHALL hold busy=1 in CALC and FIX and busy=0 in IDLE and DONE.
REQ-017 SHALL, in CALC, perform restoring division on operand magnitudes, one quotient bit per cycle, MSB first, for exactly WIDTH cycles.
REQ-018 SHALL, in FIX, apply sign correction and load quotient/remainder/div_by_zero, then go to DONE.
REQ-019 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE; start is not accepted in DONE.
REQ-020 SHALL deliver done WIDTH+2 rising edges after the start-sampling edge for b!=0, and 2 edges after for b=0.
REQ-021 SHALL, unsigned mode, produce quotient=floor(a/b), remainder=a-quotient*b.
REQ-022 SHALL, signed mode, truncate toward zero: quotient negated when operand signs differ; remainder takes the sign of a; |remainder|<|b|.
REQ-023 SHALL, signed mode with a=most-negative value and b=-1, return quotient=most-negative value, remainder=0, div_by_zero=0 (wrap, no flag).
REQ-024 SHALL, for b=0 (either mode), return quotient=all ones, remainder=a, div_by_zero=1.
REQ-025 SHALL hold quotient, remainder, div_by_zero stable from the DONE cycle until the FIX state of the next accepted operation.
REQ-026 SHALL not change quotient/remainder/div_by_zero during CALC.

Reset
REQ-027 SHALL, on rst=1, immediately (asynchronously) force state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-028 SHALL abort any in-progress operation on reset without producing done; first start after rst deasserts is accepted normally.
REQ-029 SHALL ignore start while rst=1.

Verification (WIDTH=8)
REQ-030 Unsigned a=100, b=7, start one cycle -> busy next cycle, done at edge 10, quotient=14, remainder=2, div_by_zero=0.
REQ-031 Signed a=0x9C (-100), b=7 -> quotient=0xF2 (-14), remainder=0xFE (-2); signed a=100, b=0xF9 (-7) -> quotient=0xF2, remainder=2.
REQ-032 Signed a=0x80, b=0xFF -> quotient=0x80, remainder=0, div_by_zero=0; unsigned same operands -> quotient=0, remainder=0x80.
REQ-033 a=0x55, b=0 -> done at edge 2, quotient=0xFF, remainder=0x55, div_by_zero=1; next valid division clears div_by_zero.
REQ-034 Start 200/3 then pulse start with a=9, b=2 mid-CALC -> second start ignored, result quotient=66, remainder=2, single done pulse.
REQ-035 Assert rst during CALC -> outputs zero immediately, no done pulse; subsequent 15/4 -> quotient=3, remainder=3 with normal latency.
